// File: rtl/fpu_resp_stub_if.sv
// Request/result bundle between an FPU requester and the FPU responder.
//
// Handshake semantics:
//   request: a transfer happens at a rising edge where valid_i & ready_o are
//   both 1; operands, op, rm, fn and user are sampled at that edge.
//   result: valid_o is asserted only while stall_i is low, and the consumer
//   takes the head result in every cycle valid_o is 1 (no separate ready).
interface fpu_resp_stub_if #(
  parameter int W    = 32,
  parameter int OP_W = 4,
  parameter int RM_W = 3,
  parameter int UW   = 8
);
  logic            valid_i;
  logic            ready_o;
  logic [OP_W-1:0] op_i;
  logic [W-1:0]    operand_a_i;
  logic [W-1:0]    operand_b_i;
  logic [W-1:0]    operand_c_i;
  logic [RM_W-1:0] rm_i;
  logic            fn_i;
  logic [UW-1:0]   user_i;
  logic            stall_i;
  logic            valid_o;
  logic [W-1:0]    result_o;
  logic [4:0]      fflags_o;
  logic [UW-1:0]   user_o;
  logic            error_o;

  modport slave (
    input  valid_i, op_i, operand_a_i, operand_b_i, operand_c_i, rm_i, fn_i,
           user_i, stall_i,
    output ready_o, valid_o, result_o, fflags_o, user_o, error_o
  );

  modport master (
    output valid_i, op_i, operand_a_i, operand_b_i, operand_c_i, rm_i, fn_i,
           user_i, stall_i,
    input  ready_o, valid_o, result_o, fflags_o, user_o, error_o
  );
endinterface

// File: rtl/fpu_resp_stub.sv
// Deterministic FPU stand-in: computes a simple integer result at accept,
// delays it through a fixed LAT-stage pipeline and buffers it in a DEPTH-entry
// FIFO. A credit counter covering pipeline + FIFO guarantees no overflow.
module fpu_resp_stub #(
  parameter int W     = 32,
  parameter int OP_W  = 4,
  parameter int RM_W  = 3,
  parameter int UW    = 8,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  fpu_resp_stub_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  typedef struct packed {
    logic [W-1:0]  res;
    logic [4:0]    flags;
    logic [UW-1:0] user;
    logic          err;
  } entry_t;

  entry_t          new_e;
  entry_t          head_e;
  logic            accept;
  logic            pop;
  logic            fifo_wr;
  logic            valid_o_w;
  logic            ready_o_w;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0]  pv_q;
  entry_t          pe_q [LAT];
  entry_t          mem_q [DEPTH];

  // Rounding mode is accepted on the interface but has no effect here.
  logic unused_rm;
  assign unused_rm = ^bus.rm_i;

  // Result of the request currently offered on the interface.
  always_comb begin
    new_e      = '0;
    new_e.user = bus.user_i;
    if (bus.op_i[OP_W-1:2] == '0) begin
      case (bus.op_i[1:0])
        2'd0:    new_e.res = bus.operand_a_i + bus.operand_b_i;
        2'd1:    new_e.res = bus.operand_a_i - bus.operand_b_i;
        2'd2:    new_e.res = bus.operand_a_i ^ bus.operand_b_i ^ bus.operand_c_i;
        default: new_e.res = bus.operand_c_i;
      endcase
      if (bus.fn_i) new_e.res[W-1] = ~new_e.res[W-1];
    end else begin
      new_e.res   = '1;
      new_e.flags = 5'b10000;
      new_e.err   = 1'b1;
    end
  end

  // Handshake and credit/FIFO next-state logic. ready_o sees stall_i through
  // valid_o on purpose: a pop in the same cycle frees a credit.
  always_comb begin
    head_e    = mem_q[rd_ptr_q];
    fifo_wr   = pv_q[LAT-1];
    valid_o_w = !rst && (fcnt_q != '0) && !bus.stall_i;
    ready_o_w = !rst && ((cnt_q < DEPTH_C) || valid_o_w);
    accept    = bus.valid_i && ready_o_w;
    pop       = valid_o_w;

    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    fcnt_d = fcnt_q;
    case ({fifo_wr, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + 1'b1;
  end

  // Control state: credits, FIFO occupancy, pointers, pipeline valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pv_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pv_q[0]  <= accept;
      for (int i = 1; i < LAT; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  // Pipeline payload: always shifts; only the valid bits matter after reset.
  always_ff @(posedge clk) begin
    pe_q[0] <= new_e;
    for (int i = 1; i < LAT; i++) pe_q[i] <= pe_q[i-1];
  end

  // FIFO storage, written by the last pipeline stage.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= pe_q[LAT-1];
  end

  // Credits cover the pipeline, so a write into a full FIFO cannot happen.
  always_ff @(posedge clk) begin
    if (!rst && fifo_wr && !pop) assert (fcnt_q != DEPTH_C);
  end

  assign bus.ready_o  = ready_o_w;
  assign bus.valid_o  = valid_o_w;
  assign bus.result_o = valid_o_w ? head_e.res   : '0;
  assign bus.fflags_o = valid_o_w ? head_e.flags : '0;
  assign bus.user_o   = valid_o_w ? head_e.user  : '0;
  assign bus.error_o  = valid_o_w ? head_e.err   : 1'b0;

endmodule

// File: tb/tb_fpu_resp_stub.sv
// Bench for fpu_resp_stub: directed scenarios plus a randomized stream,
// checked every cycle against a queue-based reference of the responder.
module tb_fpu_resp_stub;
  localparam int W     = 32;
  localparam int OP_W  = 4;
  localparam int RM_W  = 3;
  localparam int UW    = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int EW    = W + 5 + UW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_resp_stub_if #(.W(W), .OP_W(OP_W), .RM_W(RM_W), .UW(UW)) bus ();

  fpu_resp_stub #(
    .W(W), .OP_W(OP_W), .RM_W(RM_W), .UW(UW), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: outstanding requests in order, with the cycle each may appear.
  logic [EW-1:0] exp_q[$];
  int            arr_q[$];
  int            cyc      = 0;
  int            passed   = 0;
  int            failed   = 0;
  int            total    = 0;
  bit            last_acc = 1'b0;

  function automatic logic [EW-1:0] model(input logic [OP_W-1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c,
                                          input logic fn,
                                          input logic [UW-1:0] user);
    logic [W-1:0] r;
    logic [4:0]   f;
    logic         e;
    f = 5'd0;
    e = 1'b0;
    if (op < 4) begin
      if (op == 0)      r = a + b;
      else if (op == 1) r = a - b;
      else if (op == 2) r = a ^ b ^ c;
      else              r = c;
      if (fn) r[W-1] = ~r[W-1];
    end else begin
      r = '1;
      f = 5'b10000;
      e = 1'b1;
    end
    return {r, f, user, e};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    failed++;
    $error("FAIL %s: bound expired at cycle %0d", tag, cyc);
  endtask

  // One clock: check outputs mid-cycle, then advance the reference at the edge.
  task automatic cycle();
    logic          exp_v;
    logic          exp_r;
    logic [EW-1:0] h;
    @(negedge clk);
    exp_v = !rst && (exp_q.size() > 0) && !bus.stall_i && (arr_q[0] <= cyc);
    exp_r = !rst && ((exp_q.size() < DEPTH) || exp_v);
    h = exp_v ? exp_q[0] : '0;
    chk("valid_o",   bus.valid_o,  exp_v);
    chk("ready_o",   bus.ready_o,  exp_r);
    chk("result_o",  bus.result_o, h[EW-1 -: W]);
    chk("fflags_o",  bus.fflags_o, h[UW+5:UW+1]);
    chk("user_o",    bus.user_o,   h[UW:1]);
    chk("error_o",   bus.error_o,  h[0]);
    chk("cnt_bound", W'(dut.cnt_q <= DEPTH), 1);
    last_acc = bus.valid_i && exp_r;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      arr_q.delete();
    end else begin
      if (exp_v) begin
        void'(exp_q.pop_front());
        void'(arr_q.pop_front());
      end
      if (last_acc) begin
        exp_q.push_back(model(bus.op_i, bus.operand_a_i, bus.operand_b_i,
                              bus.operand_c_i, bus.fn_i, bus.user_i));
        arr_q.push_back(cyc + LAT);
      end
    end
    #1;
  endtask

  task automatic set_req(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic fn, input logic [UW-1:0] user);
    bus.op_i        = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    bus.operand_c_i = c;
    bus.fn_i        = fn;
    bus.user_i      = user;
    bus.rm_i        = RM_W'($urandom_range(0, 7));
  endtask

  task automatic send_op(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic fn, input logic [UW-1:0] user);
    int n;
    set_req(op, a, b, c, fn, user);
    bus.valid_i = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) timeout("send_op");
    bus.valid_i = 1'b0;
  endtask

  task automatic send_rand();
    send_op(OP_W'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), UW'($urandom_range(0, 255)));
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    int n;
    bus.valid_i = 1'b0;
    bus.stall_i = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) timeout("drain");
    idle(2);
  endtask

  initial begin
    int got;
    int guard;
    bus.valid_i = 1'b0;
    bus.stall_i = 1'b0;
    set_req('0, '0, '0, '0, 1'b0, '0);

    // Reset: all outputs held at zero.
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    idle(2);

    // Single op with exact latency.
    send_op(4'd0, 32'h0000_0005, 32'h0000_0003, 32'h0, 1'b0, 8'h5A);
    idle(5);

    // Arithmetic edges and illegal op.
    send_op(4'd1, 32'h0, 32'h1, 32'h0, 1'b0, 8'h01);
    idle(4);
    send_op(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 8'h02);
    idle(4);
    send_op(4'd3, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 8'h03);
    idle(4);
    send_op(4'd7, 32'h1, 32'h2, 32'h3, 1'b1, 8'h04);
    idle(4);
    send_op(4'd2, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 32'h1111_2222, 1'b0, 8'h05);
    idle(4);

    // Streaming: back-to-back requests.
    repeat (8) send_rand();
    drain();

    // Back-pressure: four accepted under stall, the rest after release.
    bus.stall_i = 1'b1;
    repeat (4) send_rand();
    set_req(4'd0, 32'h10, 32'h20, 32'h0, 1'b0, 8'hE5);
    bus.valid_i = 1'b1;
    repeat (4) cycle();
    bus.stall_i = 1'b0;
    send_op(4'd0, 32'h10, 32'h20, 32'h0, 1'b0, 8'hE5);
    send_op(4'd1, 32'h30, 32'h40, 32'h0, 1'b1, 8'hE6);
    drain();

    // Reset mid-flight: nothing in flight survives.
    send_rand();
    send_rand();
    set_req(4'd0, 32'h7, 32'h8, 32'h0, 1'b0, 8'hCC);
    bus.valid_i = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.valid_i = 1'b0;
    idle(6);
    send_op(4'd0, 32'h100, 32'h23, 32'h0, 1'b0, 8'h77);
    drain();

    // Random stall/valid stream with wraparound and illegal ops.
    got = 0;
    guard = 0;
    while (got < 40 && guard < 3000) begin
      bus.stall_i = 1'($urandom_range(0, 1));
      bus.valid_i = 1'($urandom_range(0, 1));
      set_req(OP_W'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), UW'($urandom_range(0, 255)));
      cycle();
      if (last_acc) got++;
      guard++;
    end
    if (got < 40) timeout("random_stream");
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fpu_resp_stub.md
# fpu_resp_stub

Synthesizable stand-in for the FPU core: the responder end of the FPU request/result interface. It accepts requests on a valid_i/ready_o handshake, computes a simple deterministic integer result, and delays it through a fixed-latency pipeline into a small output buffer. Results are presented on valid_o under consumer back-pressure (stall_i). It lets the UVM environment's driver, monitors and scoreboard be brought up against a predictable DUT before the real FPU is integrated.

## Interface
- W, 32: operand/result width.
- OP_W, 4: op_i width.
- RM_W, 3: rm_i width.
- UW, 8: user tag width.
- LAT, 3: pipeline latency in cycles; legal range 1..8.
- DEPTH, 4: output buffer entries; legal range 2..16. Full rate requires DEPTH >= LAT+1.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i & ready_o at a rising edge.
- op_i  in  OP_W  operation select.
- operand_a_i / operand_b_i / operand_c_i  in  W each  operands.
- rm_i  in  RM_W  rounding mode; captured and ignored.
- fn_i  in  1  sign-flip modifier.
- user_i  in  UW  tag returned unchanged with the result.
- stall_i  in  1  consumer stall; while high, no result is presented.
- valid_o  out  1  result valid; consumed in the same cycle it is asserted.
- result_o  out  W  result.
- fflags_o  out  5  flags {NV,DZ,OF,UF,NX}.
- user_o  out  UW  returned tag.
- error_o  out  1  illegal op.

## Operation
- Compute at accept, with W-bit wraparound arithmetic:
  - op 0: a+b
  - op 1: a-b
  - op 2: a^b^c
  - op 3: c
- If fn_i=1 on ops 0–3, bit W-1 of the result is inverted.
- op >= 4: result all ones, fflags_o=5'b10000, error_o=1; fn_i is ignored.
- Legal ops: fflags_o=0, error_o=0.
- Pipeline: a LAT-stage shift register of {valid, result, flags, user, error}. It always advances and never stalls. The last stage writes the output FIFO.
- Output FIFO: DEPTH entries, circular read/write pointers with wrap at DEPTH.
- Credit counter cnt, range 0..DEPTH, counts entries in the pipeline plus entries in the FIFO.
  - Increments on accept.
  - Decrements on pop (valid_o).
  - Accept and pop in the same cycle leave cnt unchanged.
- ready_o = !rst & (cnt < DEPTH | valid_o). This is a combinational path from stall_i to ready_o, by design.
- valid_o = !rst & FIFO non-empty & !stall_i.
- result_o, fflags_o, user_o and error_o show the FIFO head while valid_o=1, and are 0 otherwise.
- Results are returned in strict request order.
- Because credits cover the pipeline, the FIFO never overflows. Write-while-full is unreachable and is covered by an assertion.
- Reset: cnt, pointers and all pipeline valids are cleared. In-flight and buffered results are discarded and never presented.
- Reset values: ready_o=0 and valid_o=0 while rst=1; all data outputs 0. ready_o=1 in the first cycle after rst falls.

## Timing
- Accept sampled at rising edge k. The result enters the FIFO at edge k+LAT.
- valid_o is first possible in the cycle after edge k+LAT, so latency is exactly LAT when the FIFO is empty and stall_i=0.
- Throughput is one request per cycle when DEPTH >= LAT+1 and stall_i=0.
- With stall_i held high, at most DEPTH requests are accepted. ready_o falls in the cycle after the DEPTH-th accept.
- On stall_i release:
  - valid_o rises in the same cycle.
  - ready_o rises in the same cycle (pop credit).
- A full FIFO plus accept plus pop in one cycle is legal: cnt stays at DEPTH.
- rst sampled high at edge r: all outputs are 0 from edge r onward. An accept attempted in the cycle rst is high is not taken.

## Test plan
- Single op: op=0, a=0x0000_0005, b=0x0000_0003, user=0x5A -> exactly 3 cycles later valid_o=1 for one cycle, result_o=0x0000_0008, user_o=0x5A, fflags_o=0, error_o=0.
- Arithmetic edges:
  - op=1, a=0, b=1 -> 0xFFFF_FFFF.
  - op=0, a=0xFFFF_FFFF, b=1 -> 0x0000_0000.
  - op=3, c=0x1234_5678, fn_i=1 -> 0x9234_5678.
  - op=7 -> result 0xFFFF_FFFF, fflags_o=5'b10000, error_o=1.
- Streaming: 8 back-to-back ops, stall_i=0 -> ready_o stays 1; valid_o is high for 8 consecutive cycles starting 3 cycles after the first accept; results in order.
- Back-pressure: stall_i=1, valid_i held for 6 ops -> exactly 4 accepted; ready_o=0 from the cycle after the 4th accept. Drop stall_i -> valid_o high for 4 consecutive cycles, ready_o=1 in that first cycle; the remaining 2 ops follow in order; none lost or duplicated.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle after the 2nd accept edge -> no valid_o for any of them. ready_o=1 in the first cycle after rst falls; a new op returns normally 3 cycles after accept.
- Wraparound: 40 ops with random stall_i (50%) -> FIFO pointers wrap repeatedly; all 40 results in order; cnt never exceeds DEPTH; overflow assertion never fires.
